// File: rtl/enigma_pkg.sv
// Shared Enigma datapath definitions: letter range, rotor wirings,
// notches, stage FSM states and the rotor step helper.
package enigma_pkg;

    localparam int LETTER_MIN = 1;
    localparam int LETTER_MAX = 26;
    localparam int NLET       = 26;

    localparam logic [4:0] NOTCH_II  = 5'd4;
    localparam logic [4:0] NOTCH_III = 5'd21;

    localparam logic [4:0] WIRING_I [0:NLET-1] = '{
        5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21,
        5'd25, 5'd13, 5'd19, 5'd14, 5'd22, 5'd24, 5'd7,  5'd23, 5'd20,
        5'd18, 5'd15, 5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9
    };

    localparam logic [4:0] WIRING_II [0:NLET-1] = '{
        5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23,
        5'd1,  5'd11, 5'd7,  5'd22, 5'd19, 5'd12, 5'd2,  5'd16, 5'd6,
        5'd25, 5'd13, 5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4
    };

    localparam logic [4:0] WIRING_III [0:NLET-1] = '{
        5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17,
        5'd19, 5'd23, 5'd21, 5'd25, 5'd13, 5'd24, 5'd4,  5'd8,  5'd22,
        5'd6,  5'd0,  5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14
    };

    typedef enum logic [2:0] {
        IDLE,
        FWD_R,
        FWD_M,
        FWD_L,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        ROT_I,
        ROT_II,
        ROT_III
    } rotor_sel_t;

    function automatic logic [4:0] step_pos(input logic [4:0] p);
        return (p == 5'(NLET - 1)) ? 5'd0 : p + 5'd1;
    endfunction

endpackage

// File: rtl/rotor_fwd_map.sv
// Single-rotor right-to-left substitution, letters 1..26,
// positions 0..25; 6-bit intermediates keep the mod-26 sums exact.
module rotor_fwd_map
    import enigma_pkg::*;
(
    input  rotor_sel_t  sel,
    input  logic [4:0]  pos,
    input  logic [4:0]  letter,
    output logic [4:0]  result
);

    logic [5:0] sum;
    logic [4:0] c;
    logic [5:0] w;
    logic [5:0] d;
    logic [5:0] r;

    always_comb begin
        sum = 6'(letter) - 6'd1 + 6'(pos);
        c   = (sum >= 6'(NLET)) ? 5'(sum - 6'(NLET)) : 5'(sum);
        unique case (sel)
            ROT_I:   w = 6'(WIRING_I[c]);
            ROT_II:  w = 6'(WIRING_II[c]);
            ROT_III: w = 6'(WIRING_III[c]);
            default: w = '0;
        endcase
        d      = w + 6'(NLET) - 6'(pos);
        r      = (d >= 6'(NLET)) ? d - 6'(NLET) : d;
        result = 5'(r) + 5'd1;
    end

endmodule

// File: rtl/rotor_forward_stage.sv
// Enigma forward stage: steps rotors on keypress, then walks the letter
// through rotors III, II, I one per cycle and offers it to the reflector.
module rotor_forward_stage
    import enigma_pkg::*;
#(
    parameter int unsigned INIT_L = 0,
    parameter int unsigned INIT_M = 0,
    parameter int unsigned INIT_R = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] key_in,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic       load_en,
    input  logic [4:0] load_l,
    input  logic [4:0] load_m,
    input  logic [4:0] load_r,
    output logic [4:0] out_letter,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] pos_l,
    output logic [4:0] pos_m,
    output logic [4:0] pos_r,
    output logic       err
);

    state_t     state, state_nx;
    logic [4:0] cur;
    logic [4:0] map_out;
    logic [4:0] map_pos;
    rotor_sel_t map_sel;
    logic       key_ok;
    logic       accept;

    assign key_ok = (key_in >= 5'(LETTER_MIN)) && (key_in <= 5'(LETTER_MAX));
    assign accept = key_ready && key_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        key_ready = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                key_ready = !load_en;
                if (key_ready && key_valid && key_ok) state_nx = FWD_R;
            end
            FWD_R: state_nx = FWD_M;
            FWD_M: state_nx = FWD_L;
            FWD_L: state_nx = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stepping uses pre-step positions; M==notch drives the double step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_l <= 5'(INIT_L);
            pos_m <= 5'(INIT_M);
            pos_r <= 5'(INIT_R);
        end else if (state == IDLE && load_en) begin
            if (load_l < 5'(NLET)) pos_l <= load_l;
            if (load_m < 5'(NLET)) pos_m <= load_m;
            if (load_r < 5'(NLET)) pos_r <= load_r;
        end else if (accept && key_ok) begin
            pos_r <= step_pos(pos_r);
            if (pos_r == NOTCH_III || pos_m == NOTCH_II)
                pos_m <= step_pos(pos_m);
            if (pos_m == NOTCH_II)
                pos_l <= step_pos(pos_l);
        end
    end

    always_comb begin
        map_sel = ROT_III;
        map_pos = pos_r;
        case (state)
            FWD_M: begin
                map_sel = ROT_II;
                map_pos = pos_m;
            end
            FWD_L: begin
                map_sel = ROT_I;
                map_pos = pos_l;
            end
            default: ;
        endcase
    end

    rotor_fwd_map u_map (
        .sel    (map_sel),
        .pos    (map_pos),
        .letter (cur),
        .result (map_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= 5'd1;
            out_letter <= '0;
            err        <= 1'b0;
        end else begin
            err <= accept && !key_ok;
            if (accept && key_ok)
                cur <= key_in;
            if (state == FWD_R || state == FWD_M)
                cur <= map_out;
            if (state == FWD_L)
                out_letter <= map_out;
        end
    end

endmodule

// File: tb/tb_rotor_forward_stage.sv
// Directed bench for rotor_forward_stage: vector table of load/press
// cases plus sequences for back-pressure, errors, loads and reset.
module tb_rotor_forward_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] key_in;
    logic       key_valid;
    logic       key_ready;
    logic       load_en;
    logic [4:0] load_l, load_m, load_r;
    logic [4:0] out_letter;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] pos_l, pos_m, pos_r;
    logic       err;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    rotor_forward_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .load_en    (load_en),
        .load_l     (load_l),
        .load_m     (load_m),
        .load_r     (load_r),
        .out_letter (out_letter),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pos_l      (pos_l),
        .pos_m      (pos_m),
        .pos_r      (pos_r),
        .err        (err)
    );

    typedef struct {
        bit         ld;
        logic [4:0] ll, lm, lr;
        logic [4:0] key;
        logic [4:0] el, em, er;
        logic [4:0] elet;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_pos(input string name, input int l, input int m,
                             input int r);
        check({name, "_l"}, int'(pos_l), l);
        check({name, "_m"}, int'(pos_m), m);
        check({name, "_r"}, int'(pos_r), r);
    endtask

    task automatic do_load(input int l, input int m, input int r,
                           input bit with_key);
        @(negedge clk);
        load_en   = 1'b1;
        load_l    = 5'(l);
        load_m    = 5'(m);
        load_r    = 5'(r);
        key_valid = with_key;
        key_in    = 5'd1;
        @(posedge clk);
        #1;
        load_en   = 1'b0;
        key_valid = 1'b0;
    endtask

    task automatic press(input int k);
        @(negedge clk);
        key_in    = 5'(k);
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{1, 0, 0, 0,   1, 0, 0, 1,   6};
        vecs[1] = '{1, 0, 3, 21,  1, 0, 4, 22,  10};
        vecs[2] = '{0, 0, 0, 0,   1, 1, 5, 23,  1};
        vecs[3] = '{1, 0, 0, 25,  1, 0, 0, 0,   26};
        vecs[4] = '{0, 0, 0, 0,   26, 0, 0, 1,  5};
        vecs[5] = '{1, 25, 25, 25, 13, 25, 25, 0, 26};
        vecs[6] = '{1, 3, 4, 10,  5, 4, 5, 11,  19};
        vecs[7] = '{1, 25, 4, 21, 1, 0, 5, 22,  7};

        rst_n     = 1'b0;
        key_in    = 5'd0;
        key_valid = 1'b0;
        load_en   = 1'b0;
        load_l    = 5'd0;
        load_m    = 5'd0;
        load_r    = 5'd0;
        out_ready = 1'b1;
        #12;
        check("rst_valid", int'(out_valid), 0);
        check("rst_letter", int'(out_letter), 0);
        check("rst_err", int'(err), 0);
        check_pos("rst_pos", 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", int'(key_ready), 1);

        foreach (vecs[i]) begin
            if (vecs[i].ld)
                do_load(vecs[i].ll, vecs[i].lm, vecs[i].lr, 1'b0);
            press(vecs[i].key);
            check_pos($sformatf("v%0d_pos", i),
                      vecs[i].el, vecs[i].em, vecs[i].er);
            wait_valid(n);
            check($sformatf("v%0d_lat", i), n, 3);
            check($sformatf("v%0d_letter", i), int'(out_letter),
                  int'(vecs[i].elet));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_vdrop", i), int'(out_valid), 0);
            check($sformatf("v%0d_ready", i), int'(key_ready), 1);
        end

        // back-pressure with a competing keypress
        do_load(0, 0, 0, 1'b0);
        out_ready = 1'b0;
        press(1);
        wait_valid(n);
        check("bp_lat", n, 3);
        @(negedge clk);
        key_in    = 5'd2;
        key_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp_valid", int'(out_valid), 1);
            check("bp_letter", int'(out_letter), 6);
            check("bp_kready", int'(key_ready), 0);
        end
        check_pos("bp_pos", 0, 0, 1);
        @(negedge clk);
        key_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_hs_valid", int'(out_valid), 0);
        check("bp_hs_ready", int'(key_ready), 1);

        // invalid keys
        press(0);
        check("err0", int'(err), 1);
        check_pos("err0_pos", 0, 0, 1);
        @(posedge clk);
        #1;
        check("err0_drop", int'(err), 0);
        check("err0_valid", int'(out_valid), 0);
        press(27);
        check("err27", int'(err), 1);
        check_pos("err27_pos", 0, 0, 1);
        repeat (4) @(posedge clk);
        #1;
        check("err27_valid", int'(out_valid), 0);
        check("err27_drop", int'(err), 0);

        // load wins over a simultaneous key
        do_load(2, 3, 4, 1'b1);
        check_pos("ldkey_pos", 2, 3, 4);
        repeat (4) @(posedge clk);
        #1;
        check("ldkey_valid", int'(out_valid), 0);
        check_pos("ldkey_pos2", 2, 3, 4);

        // out-of-range load value leaves that rotor alone
        do_load(5, 6, 30, 1'b0);
        check_pos("ld30_pos", 5, 6, 4);

        // asynchronous reset during FWD_M
        do_load(7, 8, 9, 1'b0);
        press(1);
        check_pos("mid_pos", 7, 8, 10);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_valid", int'(out_valid), 0);
        check_pos("mid_rst_pos", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        press(1);
        check_pos("post_pos", 0, 0, 1);
        wait_valid(n);
        check("post_lat", n, 3);
        check("post_letter", int'(out_letter), 6);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
